pkt_arbiter: RTL and testbench
==============================

PKT_ARBITER -- requirements
Module: pkt_arbiter

Interface
REQ-001 Parameter: WORD_SIZE, default 4, width of each MSW/LSW half-word.
REQ-002 Parameter: BURST_LEN, default 4, maximum consecutive transfers per grant (range 1..15).
REQ-003 Parameter: RECOVER_CYC, default 2, stall cycles after a checker error (range 1..7).
REQ-004 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-high; clears all state immediately on assertion, independent of clk.
REQ-006 Port: req0_valid  in  1  requester 0 has a word pending.
REQ-007 Port: req0_msw / req0_lsw  in  WORD_SIZE each  requester 0 sequence half / flag half.
REQ-008 Port: req0_ready  out  1  requester 0 word accepted this cycle when req0_valid=1.
REQ-009 Port: req1_valid, req1_msw, req1_lsw, req1_ready  same directions, widths and meanings as REQ-006..008, for requester 1.
REQ-010 Port: error_in  in  1  Error_out from the downstream packet checker.
REQ-011 Port: out_valid  out  1  MSW/LSW carry a valid word this cycle.
REQ-012 Port: MSW / LSW  out  WORD_SIZE each  registered word driven to the checker.
REQ-013 Port: grant  out  2  one-hot current owner (bit0=req0, bit1=req1); 2'b00 when no owner.
REQ-014 Port: active_state  out  2  encoding of current state.
REQ-015 Port: drop_count  out  8  saturating count of error_in assertions.

Function
REQ-016 States and active_state encodings SHALL be: IDLE=0, GRANT0=1, GRANT1=2, RECOVER=3.
REQ-017 IDLE: if only reqN_valid=1, go to GRANTN next cycle; if both valid, grant the requester that did not hold the last grant; if neither, stay in IDLE.
REQ-018 last_grant register SHALL reset to 1, so req0 wins the first tie.
REQ-019 reqN_ready SHALL be 1 only in GRANTN; it is combinational from state; IDLE and RECOVER drive both readys 0.
REQ-020 Transfer = reqN_valid & reqN_ready; on transfer, MSW/LSW SHALL load reqN_msw/reqN_lsw and out_valid SHALL be 1 the next cycle (latency 1); otherwise out_valid SHALL be 0 and MSW/LSW hold.
REQ-021 burst counter: cleared on entering GRANTN, incremented per transfer; when it reaches BURST_LEN, or reqN_valid=0 in GRANTN, go to IDLE and set last_grant=N.
REQ-022 error_in=1 while in GRANT0 or GRANT1 SHALL force RECOVER next cycle, overriding REQ-021; a transfer in that same cycle is still accepted and its word still output next cycle.
REQ-023 RECOVER: readys 0, grant 2'b00, stay exactly RECOVER_CYC cycles, then go to IDLE; last_grant is set to the requester interrupted, so the other requester wins any tie.
REQ-024 error_in in IDLE or RECOVER SHALL not change state; it still counts per REQ-025.
REQ-025 drop_count SHALL increment by 1 for each cycle with error_in=1 and saturate at 255 (no wrap).
REQ-026 grant SHALL equal 2'b01 in GRANT0, 2'b10 in GRANT1, 2'b00 otherwise.

Reset
REQ-027 While reset=1: state=IDLE, active_state=0, grant=0, out_valid=0, MSW=0, LSW=0, drop_count=0, burst and recover counters=0, last_grant=1, req0_ready=req1_ready=0.
REQ-028 Reset asserted mid-burst or mid-RECOVER SHALL abandon the operation without emitting any further word; first grant after release follows REQ-017/018.

Verification
REQ-029 Both valid from reset release, BURST_LEN=4, req0 words MSW=0..3, LSW=F -> GRANT0 for 4 transfers, out_valid 4 cycles with MSW 0,1,2,3, IDLE 1 cycle, then GRANT1.
REQ-030 Only req1 valid, drops valid after 2 words -> 2 outputs, grant=2'b10 for 3 cycles, return to IDLE, last_grant=1.
REQ-031 error_in pulse in the cycle of req0's 2nd transfer -> 2nd word still output, RECOVER 2 cycles (active_state=3, readys 0), IDLE, then GRANT1 with both valid; drop_count=1.
REQ-032 error_in held high 300 cycles -> drop_count saturates at 255, no wrap.
REQ-033 reset asserted asynchronously between clock edges during GRANT1 -> all outputs 0 before the next edge; after release with both valid, GRANT0 first.
REQ-034 No requests valid for 10 cycles -> remain IDLE, out_valid=0, grant=0 throughout.

Source files
------------

// File: rtl/pkt_arbiter.sv
// Two-requester packet arbiter feeding a downstream checker: burst-limited
// round-robin grants, with a fixed stall after each checker error.
module pkt_arbiter #(
    parameter int WORD_SIZE   = 4,
    parameter int BURST_LEN   = 4,
    parameter int RECOVER_CYC = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    input  logic [WORD_SIZE-1:0] req0_msw,
    input  logic [WORD_SIZE-1:0] req0_lsw,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [WORD_SIZE-1:0] req1_msw,
    input  logic [WORD_SIZE-1:0] req1_lsw,
    output logic                 req1_ready,
    input  logic                 error_in,
    output logic                 out_valid,
    output logic [WORD_SIZE-1:0] MSW,
    output logic [WORD_SIZE-1:0] LSW,
    output logic [1:0]           grant,
    output logic [1:0]           active_state,
    output logic [7:0]           drop_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT0  = 2'd1,
        GRANT1  = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           burst_q, burst_d;
    logic [2:0]           rec_q, rec_d;
    logic                 last_q, last_d;   // 0: req0 held the last grant, 1: req1
    logic                 ov_q, ov_d;
    logic [WORD_SIZE-1:0] msw_q, msw_d, lsw_q, lsw_d;
    logic [7:0]           drop_q, drop_d;

    logic       xfer0, xfer1, cur_valid;
    logic [3:0] burst_inc;

    assign req0_ready   = (state_q == GRANT0);
    assign req1_ready   = (state_q == GRANT1);
    assign xfer0        = req0_valid & req0_ready;
    assign xfer1        = req1_valid & req1_ready;
    assign cur_valid    = (state_q == GRANT0) ? req0_valid : req1_valid;
    assign burst_inc    = burst_q + 4'(xfer0 | xfer1);

    assign grant        = {req1_ready, req0_ready};
    assign active_state = state_q;
    assign out_valid    = ov_q;
    assign MSW          = msw_q;
    assign LSW          = lsw_q;
    assign drop_count   = drop_q;

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        rec_d   = rec_q;
        last_d  = last_q;
        ov_d    = xfer0 | xfer1;
        msw_d   = msw_q;
        lsw_d   = lsw_q;
        drop_d  = (error_in && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

        if (xfer0) begin
            msw_d = req0_msw;
            lsw_d = req0_lsw;
        end else if (xfer1) begin
            msw_d = req1_msw;
            lsw_d = req1_lsw;
        end

        case (state_q)
            IDLE: begin
                burst_d = '0;
                rec_d   = '0;
                if (req0_valid && req1_valid) state_d = last_q ? GRANT0 : GRANT1;
                else if (req0_valid)          state_d = GRANT0;
                else if (req1_valid)          state_d = GRANT1;
            end
            GRANT0, GRANT1: begin
                burst_d = burst_inc;
                // A checker error outranks burst completion; the word accepted
                // this cycle is still forwarded.
                if (error_in) begin
                    state_d = RECOVER;
                    rec_d   = '0;
                    last_d  = (state_q == GRANT1);
                end else if (!cur_valid || burst_inc == 4'(BURST_LEN)) begin
                    state_d = IDLE;
                    last_d  = (state_q == GRANT1);
                end
            end
            RECOVER: begin
                if (rec_q == 3'(RECOVER_CYC - 1)) begin
                    state_d = IDLE;
                    rec_d   = '0;
                end else begin
                    rec_d = rec_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            burst_q <= '0;
            rec_q   <= '0;
            last_q  <= 1'b1;
            ov_q    <= 1'b0;
            msw_q   <= '0;
            lsw_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            rec_q   <= rec_d;
            last_q  <= last_d;
            ov_q    <= ov_d;
            msw_q   <= msw_d;
            lsw_q   <= lsw_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_pkt_arbiter.sv
// Directed bench for pkt_arbiter: bursts, requester drop-out, error recovery,
// drop counter saturation, async reset and idle behaviour.
module tb_pkt_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0] req0_msw = '0, req0_lsw = '0, req1_msw = '0, req1_lsw = '0;
    logic         req0_ready, req1_ready;
    logic         error_in = 1'b0;
    logic         out_valid;
    logic [W-1:0] MSW, LSW;
    logic [1:0]   grant, active_state;
    logic [7:0]   drop_count;

    int n_chk  = 0;
    int n_fail = 0;

    pkt_arbiter #(.WORD_SIZE(W), .BURST_LEN(4), .RECOVER_CYC(2)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_msw(req0_msw), .req0_lsw(req0_lsw), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_msw(req1_msw), .req1_lsw(req1_lsw), .req1_ready(req1_ready),
        .error_in(error_in), .out_valid(out_valid), .MSW(MSW), .LSW(LSW),
        .grant(grant), .active_state(active_state), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string tag, input int st, input int gr, input int ov);
        chk({tag, ".state"}, 32'(active_state), 32'(st));
        chk({tag, ".grant"}, 32'(grant), 32'(gr));
        chk({tag, ".ovalid"}, 32'(out_valid), 32'(ov));
    endtask

    initial begin
        #2;
        chk_st("reset", 0, 0, 0);
        chk("reset.msw", 32'(MSW), 0);
        chk("reset.lsw", 32'(LSW), 0);
        chk("reset.drop", 32'(drop_count), 0);
        chk("reset.rdy", 32'({req1_ready, req0_ready}), 0);

        // Both valid from release: req0 wins the first tie and bursts 4 words
        req0_valid = 1; req1_valid = 1;
        req0_msw = 0; req0_lsw = 4'hF; req1_msw = 4'h8; req1_lsw = 4'hA;
        @(negedge clk); reset = 0;
        step();
        chk_st("b.grant0", 1, 1, 0);
        chk("b.rdy", 32'({req1_ready, req0_ready}), 1);
        for (int k = 0; k < 4; k++) begin
            req0_msw = 4'(k);
            step();
            chk("b.ovalid", 32'(out_valid), 1);
            chk("b.msw", 32'(MSW), 32'(k));
            chk("b.lsw", 32'(LSW), 32'hF);
            if (k < 3) chk("b.grant", 32'(grant), 1);
            else       chk("b.idle", 32'(active_state), 0);
        end
        step();
        chk_st("b.grant1", 2, 2, 0);
        req0_valid = 0; req1_valid = 0;
        step();
        chk_st("b.drop", 0, 0, 0);

        // Only req1, drops valid after two words
        req1_valid = 1; req1_msw = 5; req1_lsw = 1;
        step();
        chk_st("r1.c1", 2, 2, 0);
        step();
        chk_st("r1.c2", 2, 2, 1);
        chk("r1.w1", 32'(MSW), 5);
        req1_msw = 6;
        step();
        chk_st("r1.c3", 2, 2, 1);
        chk("r1.w2", 32'(MSW), 6);
        req1_valid = 0;
        step();
        chk_st("r1.idle", 0, 0, 0);

        // req1 held last grant, so req0 wins this tie; error on 2nd transfer
        req0_valid = 1; req1_valid = 1; req0_msw = 1; req0_lsw = 3;
        step();
        chk_st("e.grant0", 1, 1, 0);
        step();
        chk("e.w1", 32'(MSW), 1);
        req0_msw = 2; error_in = 1;
        step();
        error_in = 0;
        chk_st("e.rec1", 3, 0, 1);
        chk("e.w2", 32'(MSW), 2);
        chk("e.rdy", 32'({req1_ready, req0_ready}), 0);
        chk("e.drop", 32'(drop_count), 1);
        step();
        chk_st("e.rec2", 3, 0, 0);
        step();
        chk_st("e.idle", 0, 0, 0);
        step();
        chk_st("e.grant1", 2, 2, 0);
        chk("e.drop2", 32'(drop_count), 1);

        // Error held for 300 cycles: counter saturates at 255
        req0_valid = 0; req1_valid = 0; error_in = 1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 252) chk("sat.254", 32'(drop_count), 254);
            if (i == 253) chk("sat.255", 32'(drop_count), 255);
        end
        chk("sat.hold", 32'(drop_count), 255);
        error_in = 0;
        step();
        chk("sat.end", 32'(drop_count), 255);

        // Idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            step();
            chk_st("idle", 0, 0, 0);
        end

        // Async reset mid-burst in GRANT1
        req1_valid = 1; req1_msw = 4'h9; req1_lsw = 4'h7;
        step();
        chk_st("ar.grant1", 2, 2, 0);
        step();
        chk("ar.ovalid", 32'(out_valid), 1);
        #3 reset = 1;
        #1;
        chk_st("ar.now", 0, 0, 0);
        chk("ar.msw", 32'(MSW), 0);
        chk("ar.lsw", 32'(LSW), 0);
        chk("ar.drop", 32'(drop_count), 0);
        chk("ar.rdy", 32'({req1_ready, req0_ready}), 0);
        req0_valid = 1; req1_valid = 1;
        step();
        chk_st("ar.held", 0, 0, 0);
        @(negedge clk); reset = 0;
        step();
        chk_st("ar.grant0", 1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
